operand_sched: RTL and testbench

//  Decode-stage operand scheduler and register scoreboard. Takes one decoded instruction (rs1/rs2/rd) per

---
 rtl/operand_sched_pkg.sv | 21 ++
 rtl/operand_sched_sb_counter_bank.sv | 70 +++++++
 rtl/operand_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_operand_sched.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_sched_pkg.sv
// Shared definitions for the decode-stage operand scheduler and its scoreboard.
package operand_sched_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] X0 = '0;

  // Wait and Rd are substates of whichever source sel_q points at.
  typedef enum logic [2:0] {
    StIdle,
    StSrc,
    StWait,
    StRd,
    StOut
  } sched_state_e;

  typedef enum logic {
    SelRs1,
    SelRs2
  } src_sel_e;

endpackage

// File: rtl/operand_sched_sb_counter_bank.sv
// Per-register pending-writer counters: one lock port and two release ports per cycle.
module operand_sched_sb_counter_bank
  import operand_sched_pkg::*;
#(
  parameter int unsigned NREG   = 32,
  parameter int unsigned PEND_W = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             inc_en_i,
  input  logic [REG_IDX_W-1:0]             inc_idx_i,
  input  logic                             dec0_en_i,
  input  logic [REG_IDX_W-1:0]             dec0_idx_i,
  input  logic                             dec1_en_i,
  input  logic [REG_IDX_W-1:0]             dec1_idx_i,
  output logic [NREG-1:0][PEND_W-1:0]      cnt_o,
  output logic [NREG-1:0]                  zero_o,
  output logic [NREG-1:0]                  full_o,
  output logic                             err_o
);

  localparam logic [PEND_W-1:0] PendOne = PEND_W'(1);
  localparam logic [PEND_W-1:0] PendTwo = PEND_W'(2);
  localparam logic [PEND_W-1:0] PendMax = '1;

  logic [NREG-1:0][PEND_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (dec0_en_i && dec0_idx_i == REG_IDX_W'(i) && dec1_en_i && dec1_idx_i == REG_IDX_W'(i)) begin
        if (cnt_q[i] > PendOne) begin
          cnt_d[i] = cnt_q[i] - PendTwo;
        end else begin
          cnt_d[i] = '0;
          err_o    = 1'b1;
        end
      end else if ((dec0_en_i && dec0_idx_i == REG_IDX_W'(i)) ||
                   (dec1_en_i && dec1_idx_i == REG_IDX_W'(i))) begin
        if (cnt_q[i] != '0) begin
          cnt_d[i] = cnt_q[i] - PendOne;
        end else begin
          err_o = 1'b1;
        end
      end
      // Applied after the release so a same-cycle lock and release net to zero.
      if (inc_en_i && inc_idx_i == REG_IDX_W'(i)) begin
        cnt_d[i] = cnt_d[i] + PendOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_o = cnt_q;
    for (int unsigned i = 0; i < NREG; i++) begin
      zero_o[i] = (cnt_q[i] == '0);
      full_o[i] = (cnt_q[i] == PendMax);
    end
  end

endmodule

// File: rtl/operand_sched.sv
// Decode-stage operand scheduler: resolves rs1/rs2 from x0, EX/MA releases or the regfile,
// stalls on RAW hazards and locks rd when operands are handed to EX.
module operand_sched
  import operand_sched_pkg::*;
#(
  parameter int unsigned REG_SZ = 32,
  parameter int unsigned NREG   = 32,
  parameter int unsigned PEND_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  output logic                 dec_ready,
  input  logic [REG_IDX_W-1:0] dec_rs1,
  input  logic                 dec_use1,
  input  logic [REG_IDX_W-1:0] dec_rs2,
  input  logic                 dec_use2,
  input  logic [REG_IDX_W-1:0] dec_rd,
  input  logic                 dec_wb,
  output logic                 rf_re,
  output logic [REG_IDX_W-1:0] rf_idx,
  input  logic                 rf_rack,
  input  logic [REG_SZ-1:0]    rf_data,
  input  logic                 ex_ack,
  input  logic [REG_IDX_W-1:0] ex_idx,
  input  logic [REG_SZ-1:0]    ex_val,
  input  logic                 ma_ack,
  input  logic [REG_IDX_W-1:0] ma_idx,
  input  logic [REG_SZ-1:0]    ma_val,
  output logic                 opr_valid,
  input  logic                 opr_ready,
  output logic [REG_SZ-1:0]    opr1,
  output logic [REG_SZ-1:0]    opr2,
  output logic                 stall,
  input  logic                 flush,
  output logic                 sb_err
);

  sched_state_e         state_q, state_d;
  src_sel_e             sel_q, sel_d;
  logic [REG_IDX_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                 use1_q, use1_d, use2_q, use2_d, wb_q, wb_d;
  logic [REG_SZ-1:0]    opr1_q, opr1_d, opr2_q, opr2_d;
  logic                 sb_err_q, sb_err_d;

  logic [NREG-1:0][PEND_W-1:0] pend_cnt;
  logic [NREG-1:0]             pend_zero, pend_full;
  logic                        cnt_err, inc_en;

  logic [REG_IDX_W-1:0] cur_idx;
  logic                 cur_use, ex_hit, ma_hit, rel_zero, lock_need, capture;
  logic [1:0]           rel_n;
  logic [PEND_W:0]      cur_cnt, rel_cnt;
  logic [REG_SZ-1:0]    rel_val, cap_val;

  operand_sched_sb_counter_bank #(
    .NREG   (NREG),
    .PEND_W (PEND_W)
  ) u_sb_counter_bank (
    .clk_i      (clk),
    .rst_ni     (rst),
    .inc_en_i   (inc_en),
    .inc_idx_i  (rd_q),
    .dec0_en_i  (ex_ack),
    .dec0_idx_i (ex_idx),
    .dec1_en_i  (ma_ack),
    .dec1_idx_i (ma_idx),
    .cnt_o      (pend_cnt),
    .zero_o     (pend_zero),
    .full_o     (pend_full),
    .err_o      (cnt_err)
  );

  assign cur_idx   = (sel_q == SelRs2) ? rs2_q : rs1_q;
  assign cur_use   = (sel_q == SelRs2) ? use2_q : use1_q;
  assign ex_hit    = ex_ack && (ex_idx == cur_idx);
  assign ma_hit    = ma_ack && (ma_idx == cur_idx);
  assign rel_n     = {1'b0, ex_hit} + {1'b0, ma_hit};
  assign cur_cnt   = {1'b0, pend_cnt[cur_idx]};
  assign rel_cnt   = (PEND_W+1)'(rel_n);
  // The release that empties the counter carries the youngest value; EX is younger than MA.
  assign rel_zero  = (cur_cnt != '0) && (rel_cnt >= cur_cnt);
  assign rel_val   = ex_hit ? ex_val : ma_val;
  assign lock_need = wb_q && (rd_q != X0);

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    use1_d    = use1_q;
    use2_d    = use2_q;
    wb_d      = wb_q;
    opr1_d    = opr1_q;
    opr2_d    = opr2_q;
    sb_err_d  = sb_err_q | cnt_err;
    dec_ready = 1'b0;
    rf_re     = 1'b0;
    opr_valid = 1'b0;
    stall     = 1'b0;
    inc_en    = 1'b0;
    capture   = 1'b0;
    cap_val   = '0;

    unique case (state_q)
      StIdle: begin
        dec_ready = !flush;
        if (dec_valid && !flush) begin
          rs1_d   = dec_rs1;
          rs2_d   = dec_rs2;
          rd_d    = dec_rd;
          use1_d  = dec_use1;
          use2_d  = dec_use2;
          wb_d    = dec_wb;
          opr1_d  = '0;
          opr2_d  = '0;
          sel_d   = SelRs1;
          state_d = StSrc;
        end
      end
      StSrc: begin
        if (!cur_use || cur_idx == X0) begin
          capture = 1'b1;
        end else if (!pend_zero[cur_idx]) begin
          if (rel_zero) begin
            capture = 1'b1;
            cap_val = rel_val;
          end else begin
            stall   = 1'b1;
            state_d = StWait;
          end
        end else begin
          rf_re = 1'b1;
          if (rf_rack) begin
            capture = 1'b1;
            cap_val = rf_data;
          end else begin
            state_d = StRd;
          end
        end
      end
      StWait: begin
        if (rel_zero) begin
          capture = 1'b1;
          cap_val = rel_val;
        end else if (pend_zero[cur_idx]) begin
          state_d = StSrc;
        end else begin
          stall = 1'b1;
        end
      end
      StRd: begin
        rf_re = 1'b1;
        if (rf_rack) begin
          capture = 1'b1;
          cap_val = rf_data;
        end
      end
      StOut: begin
        opr_valid = !(lock_need && pend_full[rd_q]);
        if (opr_valid && opr_ready) begin
          inc_en  = lock_need;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (capture) begin
      if (sel_q == SelRs1) begin
        opr1_d  = cap_val;
        sel_d   = SelRs2;
        state_d = StSrc;
      end else begin
        opr2_d  = cap_val;
        state_d = StOut;
      end
    end

    if (flush) begin
      state_d   = StIdle;
      rf_re     = 1'b0;
      stall     = 1'b0;
      opr_valid = 1'b0;
      inc_en    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      sel_q    <= SelRs1;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rd_q     <= '0;
      use1_q   <= 1'b0;
      use2_q   <= 1'b0;
      wb_q     <= 1'b0;
      opr1_q   <= '0;
      opr2_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rd_q     <= rd_d;
      use1_q   <= use1_d;
      use2_q   <= use2_d;
      wb_q     <= wb_d;
      opr1_q   <= opr1_d;
      opr2_q   <= opr2_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign rf_idx = rf_re ? cur_idx : X0;
  assign opr1   = opr1_q;
  assign opr2   = opr2_q;
  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_operand_sched.sv
// Directed bench for operand_sched: hazards, releases, counter limits, flush and reset.
module tb_operand_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, dec_ready;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_use1, dec_use2, dec_wb;
  logic        rf_re, rf_rack;
  logic [4:0]  rf_idx;
  logic [31:0] rf_data;
  logic        ex_ack, ma_ack;
  logic [4:0]  ex_idx, ma_idx;
  logic [31:0] ex_val, ma_val;
  logic        opr_valid, opr_ready;
  logic [31:0] opr1, opr2;
  logic        stall, flush, sb_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  operand_sched dut (
    .clk       (clk),
    .rst       (rst),
    .dec_valid (dec_valid),
    .dec_ready (dec_ready),
    .dec_rs1   (dec_rs1),
    .dec_use1  (dec_use1),
    .dec_rs2   (dec_rs2),
    .dec_use2  (dec_use2),
    .dec_rd    (dec_rd),
    .dec_wb    (dec_wb),
    .rf_re     (rf_re),
    .rf_idx    (rf_idx),
    .rf_rack   (rf_rack),
    .rf_data   (rf_data),
    .ex_ack    (ex_ack),
    .ex_idx    (ex_idx),
    .ex_val    (ex_val),
    .ma_ack    (ma_ack),
    .ma_idx    (ma_idx),
    .ma_val    (ma_val),
    .opr_valid (opr_valid),
    .opr_ready (opr_ready),
    .opr1      (opr1),
    .opr2      (opr2),
    .stall     (stall),
    .flush     (flush),
    .sb_err    (sb_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one instruction in an IDLE cycle; returns one cycle later (first resolve cycle).
  task automatic accept(input int rs1, input int u1, input int rs2, input int u2,
                        input int rd, input int wb);
    dec_rs1   = 5'(rs1);
    dec_use1  = 1'(u1);
    dec_rs2   = 5'(rs2);
    dec_use2  = 1'(u2);
    dec_rd    = 5'(rd);
    dec_wb    = 1'(wb);
    dec_valid = 1'b1;
    #1;
    check_eq("accept_ready", 32'(dec_ready), 1);
    tick();
    dec_valid = 1'b0;
    #1;
  endtask

  task automatic take_out(input string tag);
    opr_ready = 1'b1;
    #1;
    check_eq(tag, 32'(opr_valid), 1);
    tick();
    opr_ready = 1'b0;
    #1;
  endtask

  // Writer with no sources: OUT three cycles after accept, then locks rd.
  task automatic run_writer(input int rd);
    accept(0, 0, 0, 0, rd, 1);
    tick();
    tick();
    take_out("writer_out");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; dec_valid = 1'b0; dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    dec_use1 = 1'b0; dec_use2 = 1'b0; dec_wb = 1'b0; rf_rack = 1'b0; rf_data = '0;
    ex_ack = 1'b0; ex_idx = '0; ex_val = '0; ma_ack = 1'b0; ma_idx = '0; ma_val = '0;
    opr_ready = 1'b0; flush = 1'b0;
    tick();
    tick();
    check_eq("rst_dec_ready", 32'(dec_ready), 1);
    check_eq("rst_rf_re", 32'(rf_re), 0);
    check_eq("rst_rf_idx", 32'(rf_idx), 0);
    check_eq("rst_opr_valid", 32'(opr_valid), 0);
    check_eq("rst_opr1", opr1, 0);
    check_eq("rst_opr2", opr2, 0);
    check_eq("rst_stall", 32'(stall), 0);
    check_eq("rst_sb_err", 32'(sb_err), 0);
    rst = 1'b1;
    tick();

    // T1: add x3,x1,x2 with regfile reads
    accept(1, 1, 2, 1, 3, 1);
    check_eq("t1_rf_re1", 32'(rf_re), 1);
    check_eq("t1_rf_idx1", 32'(rf_idx), 1);
    tick();
    rf_rack = 1'b1; rf_data = 5;
    tick();
    rf_rack = 1'b0; #1;
    check_eq("t1_rf_idx2", 32'(rf_idx), 2);
    check_eq("t1_no_valid_t3", 32'(opr_valid), 0);
    tick();
    rf_rack = 1'b1; rf_data = 7;
    tick();
    rf_rack = 1'b0; #1;
    check_eq("t1_opr1", opr1, 5);
    check_eq("t1_opr2", opr2, 7);
    take_out("t1_valid_t5");
    check_eq("t1_idle", 32'(dec_ready), 1);

    // x3 is now locked: reader stalls, same-cycle EX release is taken directly
    accept(3, 1, 0, 0, 9, 0);
    check_eq("t1b_stall", 32'(stall), 1);
    check_eq("t1b_no_rd", 32'(rf_re), 0);
    ex_ack = 1'b1; ex_idx = 3; ex_val = 100; #1;
    check_eq("t1b_rel_stall", 32'(stall), 0);
    tick();
    ex_ack = 1'b0;
    tick();
    check_eq("t1b_opr1", opr1, 100);
    check_eq("t1b_opr2", opr2, 0);
    take_out("t1b_valid");

    // T2: addi x1,x0 then a reader of x1 waits for EX
    accept(0, 1, 0, 0, 1, 1);
    tick();
    tick();
    check_eq("t2_x0_latency", 32'(opr_valid), 1);
    check_eq("t2_x0_opr1", opr1, 0);
    take_out("t2_addi_out");
    accept(1, 1, 0, 0, 5, 0);
    check_eq("t2_stall_c1", 32'(stall), 1);
    check_eq("t2_rf_re_c1", 32'(rf_re), 0);
    tick();
    check_eq("t2_stall_c2", 32'(stall), 1);
    check_eq("t2_rf_re_c2", 32'(rf_re), 0);
    tick();
    ex_ack = 1'b1; ex_idx = 1; ex_val = 42; #1;
    check_eq("t2_stall_rel", 32'(stall), 0);
    check_eq("t2_rf_re_rel", 32'(rf_re), 0);
    tick();
    ex_ack = 1'b0;
    tick();
    check_eq("t2_opr1", opr1, 42);
    take_out("t2_valid");

    // T3: two writers of x4, consumer needs the second release
    run_writer(4);
    run_writer(4);
    accept(4, 1, 0, 0, 7, 0);
    ma_ack = 1'b1; ma_idx = 4; ma_val = 9; #1;
    check_eq("t3_stall_first_rel", 32'(stall), 1);
    tick();
    ma_ack = 1'b0;
    ex_ack = 1'b1; ex_idx = 4; ex_val = 11; #1;
    check_eq("t3_stall_second_rel", 32'(stall), 0);
    tick();
    ex_ack = 1'b0;
    tick();
    check_eq("t3_opr1", opr1, 11);
    take_out("t3_valid");

    // T4: EX and MA release x6 together at count 2
    run_writer(6);
    run_writer(6);
    accept(6, 1, 0, 0, 0, 0);
    ex_ack = 1'b1; ex_idx = 6; ex_val = 1;
    ma_ack = 1'b1; ma_idx = 6; ma_val = 2; #1;
    check_eq("t4_stall", 32'(stall), 0);
    tick();
    ex_ack = 1'b0; ma_ack = 1'b0;
    tick();
    check_eq("t4_opr1", opr1, 1);
    take_out("t4_valid");
    check_eq("t4_no_err", 32'(sb_err), 0);
    accept(6, 1, 0, 0, 0, 0);
    check_eq("t4_cleared_rd", 32'(rf_re), 1);
    check_eq("t4_cleared_idx", 32'(rf_idx), 6);
    tick();
    rf_rack = 1'b1; rf_data = 33;
    tick();
    rf_rack = 1'b0;
    tick();
    check_eq("t4_rf_opr1", opr1, 33);
    take_out("t4_rf_valid");

    // T7: counter saturation on x8 holds OUT until a release
    run_writer(8);
    run_writer(8);
    run_writer(8);
    accept(0, 0, 0, 0, 8, 1);
    tick();
    tick();
    check_eq("t7_full_hold", 32'(opr_valid), 0);
    opr_ready = 1'b1;
    tick();
    check_eq("t7_full_hold2", 32'(opr_valid), 0);
    ex_ack = 1'b1; ex_idx = 8; ex_val = 0;
    tick();
    ex_ack = 1'b0; #1;
    check_eq("t7_slot_freed", 32'(opr_valid), 1);
    tick();
    opr_ready = 1'b0; #1;
    check_eq("t7_idle", 32'(dec_ready), 1);

    // T5: flush during RD, late rack ignored, rd not locked
    accept(10, 1, 11, 1, 12, 1);
    check_eq("t5_rd", 32'(rf_re), 1);
    tick();
    flush = 1'b1; #1;
    check_eq("t5_flush_rf_re", 32'(rf_re), 0);
    check_eq("t5_flush_valid", 32'(opr_valid), 0);
    tick();
    flush = 1'b0;
    rf_rack = 1'b1; rf_data = 77; #1;
    check_eq("t5_idle", 32'(dec_ready), 1);
    check_eq("t5_late_rf_re", 32'(rf_re), 0);
    tick();
    rf_rack = 1'b0; #1;
    check_eq("t5_no_valid", 32'(opr_valid), 0);
    accept(12, 1, 0, 0, 0, 0);
    check_eq("t5_no_lock_rd", 32'(rf_re), 1);
    check_eq("t5_no_lock_idx", 32'(rf_idx), 12);
    check_eq("t5_no_lock_stall", 32'(stall), 0);
    tick();
    rf_rack = 1'b1; rf_data = 55;
    tick();
    rf_rack = 1'b0;
    tick();
    check_eq("t5_opr1", opr1, 55);
    take_out("t5_valid");

    // T6: reset in WAIT, then a release at count 0
    run_writer(13);
    accept(13, 1, 0, 0, 0, 0);
    check_eq("t6_stall", 32'(stall), 1);
    tick();
    rst = 1'b0;
    tick();
    check_eq("t6_dec_ready", 32'(dec_ready), 1);
    check_eq("t6_stall_rst", 32'(stall), 0);
    check_eq("t6_rf_re", 32'(rf_re), 0);
    check_eq("t6_opr_valid", 32'(opr_valid), 0);
    check_eq("t6_opr1", opr1, 0);
    check_eq("t6_sb_err_rst", 32'(sb_err), 0);
    rst = 1'b1;
    ex_ack = 1'b1; ex_idx = 13; ex_val = 3;
    tick();
    ex_ack = 1'b0; #1;
    check_eq("t6_sb_err", 32'(sb_err), 1);
    tick();
    check_eq("t6_sb_err_sticky", 32'(sb_err), 1);
    accept(8, 1, 0, 0, 0, 0);
    check_eq("t6_x8_cleared", 32'(rf_re), 1);
    check_eq("t6_x8_no_stall", 32'(stall), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
